// File: rtl/mips_pkg.sv
// Shared types and defaults for the memory-port arbiter.
package mips_pkg;

  // Owner register encoding: idle, CPU holds the port, debug holds the port (locked burst).
  typedef enum logic [1:0] {ARB_IDLE, ARB_CPU, ARB_DBG} arb_state_t;

  // Consecutive CPU grants tolerated while the debug port is waiting.
  localparam int unsigned MaxStreakDefault = 4;

  localparam int unsigned AddrWDefault = 32;
  localparam int unsigned DataWDefault = 32;

endpackage

// File: rtl/arb_rd_return.sv
// Read-return path: captures memory read data for the access granted this cycle
// and steers it to whichever requester issued that read, independent of who owns
// the port in the following cycle.
module arb_rd_return #(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              rd_cpu_i,
  input  logic              rd_dbg_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              cpu_rvalid_o,
  output logic [DATA_W-1:0] cpu_rdata_o,
  output logic              dbg_rvalid_o,
  output logic [DATA_W-1:0] dbg_rdata_o
);

  logic              rvalid_q;
  logic              owner_dbg_q;  // last_read_owner: 1 = debug port, 0 = CPU
  logic [DATA_W-1:0] rdata_q;

  // Register the read data and its owner tag at the end of the granted cycle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rvalid_q    <= 1'b0;
      owner_dbg_q <= 1'b0;
      rdata_q     <= '0;
    end else begin
      rvalid_q <= rd_cpu_i | rd_dbg_i;
      if (rd_cpu_i | rd_dbg_i) begin
        owner_dbg_q <= rd_dbg_i;
        rdata_q     <= mem_rdata_i;
      end
    end
  end

  // Demux the return to the tagged owner.
  always_comb begin
    cpu_rvalid_o = rvalid_q & ~owner_dbg_q;
    dbg_rvalid_o = rvalid_q &  owner_dbg_q;
    cpu_rdata_o  = rdata_q;
    dbg_rdata_o  = rdata_q;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single-port memory between the CPU datapath and a debug/loader port.
// CPU has priority, but the debug port wins after MAX_STREAK consecutive CPU grants
// made while it was waiting. A locked debug burst keeps ownership and stalls the CPU.
module mem_port_arbiter
  import mips_pkg::*;
#(
  parameter int unsigned ADDR_W     = AddrWDefault,
  parameter int unsigned DATA_W     = DataWDefault,
  parameter int unsigned MAX_STREAK = MaxStreakDefault
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_wr,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_stall,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dbg_req,
  input  logic              dbg_lock,
  input  logic              dbg_wr,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_gnt,
  output logic              dbg_rvalid,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int unsigned StreakW = $clog2(MAX_STREAK + 1);
  localparam logic [StreakW-1:0] StreakMax = StreakW'(MAX_STREAK);

  arb_state_t         state_q, state_d;
  logic [StreakW-1:0] streak_q, streak_d;
  logic               cpu_gnt, dbg_gnt_c;

  // Owner register and starvation counter.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= ARB_IDLE;
      streak_q <= '0;
    end else begin
      state_q  <= state_d;
      streak_q <= streak_d;
    end
  end

  // Grant decision for this cycle; reset forces no grant so an in-flight write is dropped.
  always_comb begin
    cpu_gnt   = 1'b0;
    dbg_gnt_c = 1'b0;
    state_d   = ARB_IDLE;
    streak_d  = streak_q;
    if (!reset) begin
      case (state_q)
        ARB_DBG: begin
          if (dbg_req) begin
            dbg_gnt_c = 1'b1;
            state_d   = dbg_lock ? ARB_DBG : ARB_IDLE;
          end
        end
        default: begin
          if (cpu_req && !(dbg_req && (streak_q == StreakMax))) begin
            cpu_gnt = 1'b1;
            state_d = ARB_CPU;
            if (!dbg_req) begin
              streak_d = '0;
            end else if (streak_q != StreakMax) begin
              streak_d = streak_q + 1'b1;
            end
          end else if (dbg_req) begin
            dbg_gnt_c = 1'b1;
            streak_d  = '0;
            state_d   = dbg_lock ? ARB_DBG : ARB_IDLE;
          end
        end
      endcase
    end
  end

  // Address/data mux toward memory; idle bus parks at zero.
  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wr    = 1'b0;
    if (cpu_gnt) begin
      mem_addr  = cpu_addr;
      mem_wr    = cpu_wr;
      mem_wdata = cpu_wr ? cpu_wdata : '0;
    end else if (dbg_gnt_c) begin
      mem_addr  = dbg_addr;
      mem_wr    = dbg_wr;
      mem_wdata = dbg_wr ? dbg_wdata : '0;
    end
    cpu_stall = cpu_req & ~cpu_gnt & ~reset;
    dbg_gnt   = dbg_gnt_c;
  end

  arb_rd_return #(
    .DATA_W(DATA_W)
  ) u_rd_return (
    .clk_i       (clock),
    .rst_i       (reset),
    .rd_cpu_i    (cpu_gnt & ~cpu_wr),
    .rd_dbg_i    (dbg_gnt_c & ~dbg_wr),
    .mem_rdata_i (mem_rdata),
    .cpu_rvalid_o(cpu_rvalid),
    .cpu_rdata_o (cpu_rdata),
    .dbg_rvalid_o(dbg_rvalid),
    .dbg_rdata_o (dbg_rdata)
  );

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: a per-cycle reference model pushes the
// expected port behaviour; a negedge monitor pops and compares.
module tb_mem_port_arbiter;

  localparam int MaxStreak = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        cpu_req = 1'b0, cpu_wr = 1'b0;
  logic [31:0] cpu_addr = '0, cpu_wdata = '0;
  logic        cpu_stall, cpu_rvalid;
  logic [31:0] cpu_rdata;
  logic        dbg_req = 1'b0, dbg_lock = 1'b0, dbg_wr = 1'b0;
  logic [31:0] dbg_addr = '0, dbg_wdata = '0;
  logic        dbg_gnt, dbg_rvalid;
  logic [31:0] dbg_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_wr;

  always #5 clock = ~clock;

  mem_port_arbiter #(
    .ADDR_W    (32),
    .DATA_W    (32),
    .MAX_STREAK(MaxStreak)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .cpu_req   (cpu_req),
    .cpu_wr    (cpu_wr),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_stall (cpu_stall),
    .cpu_rvalid(cpu_rvalid),
    .cpu_rdata (cpu_rdata),
    .dbg_req   (dbg_req),
    .dbg_lock  (dbg_lock),
    .dbg_wr    (dbg_wr),
    .dbg_addr  (dbg_addr),
    .dbg_wdata (dbg_wdata),
    .dbg_gnt   (dbg_gnt),
    .dbg_rvalid(dbg_rvalid),
    .dbg_rdata (dbg_rdata),
    .mem_addr  (mem_addr),
    .mem_wr    (mem_wr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  // Memory attached to the DUT (combinational read, write at the clock edge).
  logic [31:0] dut_mem [0:63];
  logic [31:0] ref_mem [0:63];
  assign mem_rdata = dut_mem[mem_addr[7:2]];
  always @(posedge clock) if (mem_wr) dut_mem[mem_addr[7:2]] <= mem_wdata;

  typedef struct {
    bit          stall;
    bit          gnt;
    bit          wr;
    bit          granted;
    logic [31:0] addr;
    logic [31:0] wdata;
    bit          cpu_rv;
    bit          dbg_rv;
    logic [31:0] rdata;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  // Reference model state: lock held by debug, CPU streak, pending read return.
  bit          m_locked   = 1'b0;
  int          m_streak   = 0;
  bit          m_pend_cpu = 1'b0;
  bit          m_pend_dbg = 1'b0;
  logic [31:0] m_pend_data = '0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endfunction

  // One cycle of stimulus plus the expected response from the arbitration rules.
  task automatic drive(input bit c_req, input bit c_wr, input logic [31:0] c_addr,
                       input logic [31:0] c_wd, input bit d_req, input bit d_lock,
                       input bit d_wr, input logic [31:0] d_addr, input logic [31:0] d_wd,
                       output bit cg, output bit dg);
    exp_t e;
    @(posedge clock);
    #1;
    cpu_req = c_req; cpu_wr = c_wr; cpu_addr = c_addr; cpu_wdata = c_wd;
    dbg_req = d_req; dbg_lock = d_lock; dbg_wr = d_wr; dbg_addr = d_addr; dbg_wdata = d_wd;
    cg = 1'b0;
    dg = 1'b0;
    if (m_locked) begin
      dg       = d_req;
      m_locked = d_req && d_lock;
    end else if (c_req && !(d_req && m_streak == MaxStreak)) begin
      cg       = 1'b1;
      m_streak = d_req ? ((m_streak < MaxStreak) ? m_streak + 1 : MaxStreak) : 0;
    end else if (d_req) begin
      dg       = 1'b1;
      m_streak = 0;
      m_locked = d_lock;
    end
    e.stall   = c_req && !cg;
    e.gnt     = dg;
    e.wr      = (cg && c_wr) || (dg && d_wr);
    e.granted = cg || dg;
    e.addr    = cg ? c_addr : d_addr;
    e.wdata   = cg ? c_wd : d_wd;
    e.cpu_rv  = m_pend_cpu;
    e.dbg_rv  = m_pend_dbg;
    e.rdata   = m_pend_data;
    m_pend_cpu = cg && !c_wr;
    m_pend_dbg = dg && !d_wr;
    if (m_pend_cpu || m_pend_dbg) m_pend_data = ref_mem[e.addr[7:2]];
    if (e.wr) ref_mem[e.addr[7:2]] = e.wdata;
    sb_q.push_back(e);
  endtask

  function automatic logic [31:0] rand_addr();
    return 32'($urandom_range(0, 63)) << 2;
  endfunction

  // Monitor: compare whatever the DUT presents this cycle against the queued expectation.
  always @(negedge clock) begin
    exp_t e;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check("cpu_stall", 32'(cpu_stall), 32'(e.stall));
      check("dbg_gnt", 32'(dbg_gnt), 32'(e.gnt));
      check("mem_wr", 32'(mem_wr), 32'(e.wr));
      if (e.granted) check("mem_addr", mem_addr, e.addr);
      if (e.wr) check("mem_wdata", mem_wdata, e.wdata);
      check("cpu_rvalid", 32'(cpu_rvalid), 32'(e.cpu_rv));
      check("dbg_rvalid", 32'(dbg_rvalid), 32'(e.dbg_rv));
      if (e.cpu_rv) check("cpu_rdata", cpu_rdata, e.rdata);
      if (e.dbg_rv) check("dbg_rdata", dbg_rdata, e.rdata);
    end
  end

  initial begin
    bit cg, dg;
    int k;
    logic [31:0] v;
    for (int i = 0; i < 64; i++) begin
      v = $urandom;
      dut_mem[i] = v;
      ref_mem[i] = v;
    end
    dut_mem[4] = 32'hDEADBEEF;
    ref_mem[4] = 32'hDEADBEEF;

    // Reset values while both requesters are asking.
    cpu_req = 1'b1; cpu_wr = 1'b1; cpu_addr = 32'h44; cpu_wdata = 32'h55;
    dbg_req = 1'b1; dbg_wr = 1'b1; dbg_addr = 32'h48; dbg_wdata = 32'h66;
    #12;
    check("rst_cpu_stall", 32'(cpu_stall), 32'd0);
    check("rst_dbg_gnt", 32'(dbg_gnt), 32'd0);
    check("rst_mem_wr", 32'(mem_wr), 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_cpu_rvalid", 32'(cpu_rvalid), 32'd0);
    check("rst_dbg_rvalid", 32'(dbg_rvalid), 32'd0);
    cpu_req = 1'b0; dbg_req = 1'b0; cpu_wr = 1'b0; dbg_wr = 1'b0;
    @(negedge clock);
    reset = 1'b0;

    // CPU read of 0x10 returning 0xDEADBEEF.
    drive(1, 0, 32'h10, 0, 0, 0, 0, 0, 0, cg, dg);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, cg, dg);

    // Both requesting continuously: debug wins every fifth cycle.
    for (int i = 0; i < 10; i++)
      drive(1, 0, rand_addr(), 0, 1, 0, 0, rand_addr(), 0, cg, dg);

    // Locked debug burst writing 0x0..0xC while the CPU keeps requesting.
    k = 0;
    for (int it = 0; it < 20 && k < 4; it++) begin
      drive(1, 0, rand_addr(), 0, 1, (k < 3), 1, 32'(k * 4), 32'hA000 + 32'(k), cg, dg);
      if (dg) k++;
    end
    check("burst_done", 32'(k), 32'd4);
    drive(1, 0, 32'h0, 0, 0, 0, 0, 0, 0, cg, dg);
    drive(1, 0, 32'hC, 0, 0, 0, 0, 0, 0, cg, dg);

    // Debug read followed immediately by a CPU read: returns stay with their owners.
    drive(0, 0, 0, 0, 1, 0, 0, 32'h20, 0, cg, dg);
    drive(1, 0, 32'h24, 0, 0, 0, 0, 0, 0, cg, dg);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, cg, dg);

    // Quiet bus.
    for (int i = 0; i < 10; i++) drive(0, 0, 0, 0, 0, 0, 0, 0, 0, cg, dg);

    // Randomised traffic.
    for (int i = 0; i < 400; i++)
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, rand_addr(), $urandom,
            $urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1,
            rand_addr(), $urandom, cg, dg);

    // Reset in the middle of a CPU write to 0x40 with a debug read return pending.
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, cg, dg);
    drive(0, 0, 0, 0, 1, 0, 0, 32'h20, 0, cg, dg);
    @(posedge clock);
    #1;
    cpu_req = 1'b1; cpu_wr = 1'b1; cpu_addr = 32'h40; cpu_wdata = ~ref_mem[16];
    dbg_req = 1'b0; dbg_lock = 1'b0;
    #2;
    check("pre_rst_mem_wr", 32'(mem_wr), 32'd1);
    check("pre_rst_dbg_rvalid", 32'(dbg_rvalid), 32'd1);
    reset = 1'b1;
    #1;
    check("midrst_mem_wr", 32'(mem_wr), 32'd0);
    check("midrst_mem_addr", mem_addr, 32'd0);
    check("midrst_cpu_stall", 32'(cpu_stall), 32'd0);
    check("midrst_dbg_rvalid", 32'(dbg_rvalid), 32'd0);
    @(posedge clock);
    #1;
    check("midrst_mem40", dut_mem[16], ref_mem[16]);
    check("midrst_cpu_rvalid", 32'(cpu_rvalid), 32'd0);
    check("midrst_dbg_gnt", 32'(dbg_gnt), 32'd0);
    cpu_req = 1'b0; cpu_wr = 1'b0;
    m_locked = 1'b0; m_streak = 0; m_pend_cpu = 1'b0; m_pend_dbg = 1'b0;
    @(negedge clock);
    reset = 1'b0;

    // Traffic after reset resumes from a clean state.
    for (int i = 0; i < 12; i++)
      drive(1, 0, rand_addr(), 0, 1, 0, 0, rand_addr(), 0, cg, dg);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, cg, dg);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, cg, dg);
    @(negedge clock);
    @(negedge clock);
    check("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
